// File: rtl/seqgen_pkg.sv
// seqgen_pkg: shared types, defaults and helpers for the seqgen serial frame
// transmitter.
//   state_t      - transmitter FSM states
//   DEF_SYNC_W   - default sync pattern length
//   DEF_SYNC     - default sync pattern (sent MSB first)
//   DEF_DATA_W   - default payload width
//   max_int      - elaboration-time max used for register sizing
//   even_parity  - parity bit that makes data+parity contain an even number of 1s
package seqgen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_PAR
  } state_t;

  localparam int DEF_SYNC_W = 6;
  localparam logic [DEF_SYNC_W-1:0] DEF_SYNC = 6'b101010;
  localparam int DEF_DATA_W = 8;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Callers zero-extend the payload; the extra zeros do not change the XOR.
  function automatic logic even_parity(input logic [63:0] value);
    return ^value;
  endfunction

endpackage

// File: rtl/seqgen_shift_out.sv
// shift_out: loadable MSB-first shift register with an integrated bit counter.
// The register is loaded left-aligned together with the number of valid bits
// in the field; each shift presents the next bit on msb.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   load        - load load_val/load_len, clear the bit counter
//   shift       - advance one bit
//   load_val    - left-aligned field to send
//   load_len    - number of valid bits in load_val
//   msb         - bit currently presented (registered)
//   last        - msb is the final bit of the loaded field
//   next_last   - one more shift will present the final bit
module shift_out
  import seqgen_pkg::*;
#(
  parameter int W     = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [W-1:0]     load_val,
  input  logic [CNT_W-1:0] load_len,
  output logic             msb,
  output logic             last,
  output logic             next_last
);

  logic [W-1:0]     sr;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] len;

  // Load has priority so a field change never loses its first bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr  <= '0;
      cnt <= '0;
      len <= '0;
    end else if (load) begin
      sr  <= load_val;
      cnt <= '0;
      len <= load_len;
    end else if (shift) begin
      sr  <= {sr[W-2:0], 1'b0};
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Compare one bit wider so len values near the counter limit cannot wrap.
  assign last      = ({1'b0, cnt} + (CNT_W+1)'(1)) == {1'b0, len};
  assign next_last = ({1'b0, cnt} + (CNT_W+1)'(2)) == {1'b0, len};
  assign msb       = sr[W-1];

endmodule

// File: rtl/seqgen.sv
// seqgen: serial frame transmitter. On an accepted start it sends the sync
// pattern, then the payload byte, then (optionally) an even-parity bit, one
// bit per clock, MSB first.
// Ports:
//   clk    - clock
//   rst    - asynchronous active-high reset
//   start  - request to send din (accepted in IDLE or in the done cycle)
//   din    - payload, captured on the accepted start edge
//   prtx   - serial data line, 0 when idle
//   txen   - high while prtx carries a frame bit
//   busy   - high from the cycle after acceptance through the last bit
//   done   - one-cycle pulse coincident with the last frame bit
module seqgen
  import seqgen_pkg::*;
#(
  parameter int                SYNC_W = DEF_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC   = DEF_SYNC,
  parameter int                DATA_W = DEF_DATA_W,
  parameter int                PAR_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] din,
  output logic              prtx,
  output logic              txen,
  output logic              busy,
  output logic              done
);

  localparam int SR_W  = max_int(SYNC_W, DATA_W);
  localparam int CNT_W = $clog2(SR_W + 1);

  localparam logic [SR_W-1:0] SYNC_VAL = SR_W'(SYNC) << (SR_W - SYNC_W);

  // The state whose last bit ends the frame; done and back-to-back accept key off it.
  localparam state_t FINAL_ST = (PAR_EN != 0) ? ST_PAR : ST_DATA;

  state_t            state;
  state_t            next_state;
  logic [DATA_W-1:0] data_q;
  logic              par_q;
  logic              accept;
  logic              load;
  logic              shift;
  logic [SR_W-1:0]   load_val;
  logic [CNT_W-1:0]  load_len;
  logic              last;
  logic              next_last;
  logic              busy_d;
  logic              done_d;

  // The shift register output is itself a flop, so prtx is glitch-free.
  shift_out #(
    .W     (SR_W),
    .CNT_W (CNT_W)
  ) u_shift (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .shift     (shift),
    .load_val  (load_val),
    .load_len  (load_len),
    .msb       (prtx),
    .last      (last),
    .next_last (next_last)
  );

  // Next-state logic. Start is honoured only in IDLE or on the final bit of a
  // frame (the done cycle), which gives gap-free back-to-back frames.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    shift      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          next_state = ST_SYNC;
        end
      end
      ST_SYNC: begin
        if (last) next_state = ST_DATA;
        else      shift      = 1'b1;
      end
      ST_DATA: begin
        if (!last) begin
          shift = 1'b1;
        end else if (PAR_EN != 0) begin
          next_state = ST_PAR;
        end else if (start) begin
          accept     = 1'b1;
          next_state = ST_SYNC;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_PAR: begin
        if (start) begin
          accept     = 1'b1;
          next_state = ST_SYNC;
        end else begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Every state change reloads the shift register with the next field. Going
  // to IDLE loads zeros so the line rests at 0. The payload is loaded from
  // data_q, which was captured at acceptance, so later din changes are ignored.
  always_comb begin
    load     = 1'b0;
    load_val = '0;
    load_len = '0;
    if (next_state != state || accept) begin
      load = 1'b1;
      unique case (next_state)
        ST_SYNC: begin
          load_val = SYNC_VAL;
          load_len = CNT_W'(SYNC_W);
        end
        ST_DATA: begin
          load_val = SR_W'(data_q) << (SR_W - DATA_W);
          load_len = CNT_W'(DATA_W);
        end
        ST_PAR: begin
          load_val = SR_W'(par_q) << (SR_W - 1);
          load_len = CNT_W'(1);
        end
        default: begin
          load_val = '0;
          load_len = '0;
        end
      endcase
    end
  end

  // Output flags are computed one cycle early so they line up with the bit
  // that the shift register will present after the same edge.
  always_comb begin
    busy_d = (next_state != ST_IDLE);
    done_d = 1'b0;
    if (next_state == FINAL_ST) begin
      done_d = load ? (load_len == CNT_W'(1)) : next_last;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      data_q <= '0;
      par_q  <= 1'b0;
      busy   <= 1'b0;
      txen   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= busy_d;
      txen  <= busy_d;
      done  <= done_d;
      if (accept) begin
        data_q <= din;
        par_q  <= even_parity(64'(din));
      end
    end
  end

endmodule

// File: tb/tb_seqgen.sv
// tb_seqgen: self-checking bench for seqgen. Two instances share the inputs:
// u_par (parity enabled, 15-bit frames) and u_nopar (14-bit frames). A
// frame-position model predicts every output each cycle.
module tb_seqgen;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] din;

  logic prtx0, txen0, busy0, done0;
  logic prtx1, txen1, busy1, done1;

  int checks   = 0;
  int failures = 0;

  localparam logic [5:0]  SYNC_PAT = 6'b101010;
  localparam logic [14:0] A5_FRAME = 15'b101010_10100101_0;

  // Reference model state per instance: 0 = parity build, 1 = no-parity build.
  bit         m_act  [2];
  int         m_pos  [2];
  logic [7:0] m_data [2];

  // Loopback detector state.
  bit         det_on   = 1'b0;
  logic [5:0] det_hist = '0;
  int         det_hits = 0;

  seqgen #(.PAR_EN(1)) u_par (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .din   (din),
    .prtx  (prtx0),
    .txen  (txen0),
    .busy  (busy0),
    .done  (done0)
  );

  seqgen #(.PAR_EN(0)) u_nopar (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .din   (din),
    .prtx  (prtx1),
    .txen  (txen1),
    .busy  (busy1),
    .done  (done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int frameLen(input int idx);
    return (idx == 0) ? 15 : 14;
  endfunction

  // Bit at position pos of a frame carrying payload d.
  function automatic logic frameBit(input logic [7:0] d, input int pos);
    if (pos < 6)       return SYNC_PAT[5-pos];
    else if (pos < 14) return d[13-pos];
    else               return ^d;
  endfunction

  // Frame-position model: a frame starts on start in idle or on its last bit.
  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_act[i] = 1'b0;
        m_pos[i] = 0;
      end else if (start && (!m_act[i] || m_pos[i] == frameLen(i) - 1)) begin
        m_act[i]  = 1'b1;
        m_pos[i]  = 0;
        m_data[i] = din;
      end else if (m_act[i]) begin
        m_pos[i]++;
        if (m_pos[i] >= frameLen(i)) begin
          m_act[i] = 1'b0;
          m_pos[i] = 0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkOutput();
    logic ep, et, ed, det;
    for (int i = 0; i < 2; i++) begin
      et = m_act[i];
      ep = m_act[i] ? frameBit(m_data[i], m_pos[i]) : 1'b0;
      ed = m_act[i] && (m_pos[i] == frameLen(i) - 1);
      if (i == 0) begin
        chk("par_prtx", prtx0, ep);
        chk("par_txen", txen0, et);
        chk("par_busy", busy0, et);
        chk("par_done", done0, ed);
      end else begin
        chk("nopar_prtx", prtx1, ep);
        chk("nopar_txen", txen1, et);
        chk("nopar_busy", busy1, et);
        chk("nopar_done", done1, ed);
      end
    end
    if (det_on) begin
      det_hist = {det_hist[4:0], prtx0};
      det = (det_hist == 6'b101010);
      if (det) det_hits++;
      chk("loop_det", det, m_act[0] && (m_pos[0] == 5));
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [7:0] d);
    start = s;
    din   = d;
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    $display("[TB] seqgen bench starting");
    rst   = 1'b1;
    start = 1'b1;
    din   = 8'h00;

    // Reset held with start asserted: nothing may leave the transmitter.
    repeat (3) applyStimulus(1'b1, 8'($urandom));
    chk("rst_prtx", prtx0, 1'b0);
    chk("rst_busy", busy0, 1'b0);
    rst = 1'b0;
    repeat (2) applyStimulus(1'b0, 8'h00);

    // Single frame of A5, also checked against a literal bit table.
    applyStimulus(1'b1, 8'hA5);
    chk("a5_bit", prtx0, A5_FRAME[14]);
    for (int k = 1; k < 15; k++) begin
      applyStimulus(1'b0, 8'($urandom));
      chk("a5_bit", prtx0, A5_FRAME[14-k]);
    end
    chk("a5_done", done0, 1'b1);
    repeat (3) applyStimulus(1'b0, 8'h00);
    chk("a5_idle", prtx0, 1'b0);

    // 01 then 00 back-to-back, second start raised in the done cycle.
    applyStimulus(1'b1, 8'h01);
    repeat (14) applyStimulus(1'b0, 8'h01);
    chk("b2b_par1", prtx0, 1'b1);
    chk("b2b_done", done0, 1'b1);
    applyStimulus(1'b1, 8'h00);
    chk("b2b_busy", busy0, 1'b1);
    chk("b2b_sync0", prtx0, 1'b1);
    repeat (14) applyStimulus(1'b0, 8'h00);
    chk("b2b_par0", prtx0, 1'b0);
    repeat (2) applyStimulus(1'b0, 8'h00);

    // Ignored mid-frame start with din changed to FF.
    applyStimulus(1'b1, 8'h5A);
    repeat (4) applyStimulus(1'b0, 8'h5A);
    applyStimulus(1'b1, 8'hFF);
    repeat (14) applyStimulus(1'b0, 8'hFF);
    chk("ign_idle", busy0, 1'b0);

    // Asynchronous reset during bit 9 (din[4]=1, so prtx is high before).
    applyStimulus(1'b1, 8'hF0);
    repeat (9) applyStimulus(1'b0, 8'hF0);
    chk("mid_bit9", prtx0, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_prtx", prtx0, 1'b0);
    chk("mid_rst_txen", txen0, 1'b0);
    chk("mid_rst_busy", busy0, 1'b0);
    chk("mid_rst_nopar", txen1, 1'b0);
    applyStimulus(1'b0, 8'h00);
    rst = 1'b0;
    repeat (3) applyStimulus(1'b0, 8'h00);

    // Loopback of 3C into a 101010 detector: exactly one hit, at bit 5.
    det_on   = 1'b1;
    det_hist = '0;
    det_hits = 0;
    applyStimulus(1'b1, 8'h3C);
    repeat (16) applyStimulus(1'b0, 8'h00);
    det_on = 1'b0;
    checks++;
    assert (det_hits == 1) else begin
      failures++;
      $error("[TB] FAIL loop_hits observed=%0d expected=1", det_hits);
    end

    // Random traffic, including starts landing in done cycles.
    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom_range(0, 5) == 0), 8'($urandom));
    end
    repeat (16) applyStimulus(1'b0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
